// File: rtl/control_pkg.sv
// Shared types and encodings for the RV32I pipeline control unit.
package control_pkg;

  localparam int unsigned CTRL_ALU_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_MD  = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic [1:0]            result_src;
    logic [CTRL_ALU_W-1:0] alu_ctrl;
    logic                  is_md;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [CTRL_ALU_W-1:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational ID-stage decoder: instruction word to control bundle,
// immediate format and illegal flag.
module instr_decoder
  import control_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned M_EXT     = 1
) (
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output ctrl_t       ctrl_d,
  output logic [2:0]  imm_src_d,
  output logic        illegal_d
);

  localparam logic [CTRL_ALU_W-1:0] ALU_MASK = CTRL_ALU_W'((1 << ALUCTRL_W) - 1);

  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       legal, use_rd, use_rs1, use_rs2;
  logic [2:0] imm;
  ctrl_t      c;

  assign op = instr_d[6:0];
  assign f3 = instr_d[14:12];
  assign f7 = instr_d[31:25];

  always_comb begin
    c       = '0;
    imm     = IMM_I;
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_R: begin
        {use_rd, use_rs1, use_rs2} = 3'b111;
        c.reg_write = 1'b1;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          legal      = 1'b1;
          c.alu_ctrl = alu_code(f3, f7[5]);
        end else if (M_EXT != 0 && f7 == 7'h01) begin
          legal        = 1'b1;
          c.is_md      = 1'b1;
          c.result_src = RES_MD;
          c.alu_ctrl   = {1'b0, f3};
        end
      end
      OP_I: begin
        {use_rd, use_rs1} = 2'b11;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        // imm[10] only means "arithmetic" for shift-right; addi with a negative imm stays ADD
        c.alu_ctrl  = alu_code(f3, (f3 == 3'b101) & f7[5]);
        legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      OP_LOAD: begin
        {use_rd, use_rs1} = 2'b11;
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = RES_MEM;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OP_STORE: begin
        {use_rs1, use_rs2} = 2'b11;
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        imm         = IMM_S;
        legal       = (f3 < 3'd3);
      end
      OP_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
        imm        = IMM_B;
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_JAL: begin
        use_rd       = 1'b1;
        c.jump       = 1'b1;
        c.reg_write  = 1'b1;
        c.result_src = RES_PC4;
        imm          = IMM_J;
        legal        = 1'b1;
      end
      OP_JALR: begin
        {use_rd, use_rs1} = 2'b11;
        c.jump       = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = RES_PC4;
        legal        = (f3 == 3'b000);
      end
      OP_LUI, OP_AUIPC: begin
        use_rd      = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        imm         = IMM_U;
        legal       = 1'b1;
      end
      default: ;
    endcase
    c.alu_ctrl = c.alu_ctrl & ALU_MASK;
    if (legal && valid_d) begin
      c.valid   = 1'b1;
      c.rd      = use_rd  ? instr_d[11:7]  : 5'd0;
      c.rs1     = use_rs1 ? instr_d[19:15] : 5'd0;
      c.rs2     = use_rs2 ? instr_d[24:20] : 5'd0;
      ctrl_d    = c;
      imm_src_d = imm;
    end else begin
      ctrl_d    = '0;
      imm_src_d = IMM_I;
    end
    illegal_d = valid_d & ~legal;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline controller: ID decode, EX/MEM/WB control registers, stall/flush/
// forward generation and the multi-cycle MUL/DIV sequencer.
module pipeline_control_unit
  import control_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter int unsigned M_EXT     = 1,
  parameter int unsigned FWD_EN    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        pcsrc_e,
  input  logic        md_done,
  output ctrl_t       ctrl_e,
  output ctrl_t       ctrl_m,
  output ctrl_t       ctrl_w,
  output logic [2:0]  imm_src_d,
  output logic        illegal_d,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        md_start
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t state, state_nx;
  ctrl_t     ctrl_d;
  logic      rst_q, quiet, md_in_e, md_hold, e_hold, load_use, raw, hazard;

  instr_decoder #(.ALUCTRL_W(ALUCTRL_W), .M_EXT(M_EXT)) u_dec (
    .instr_d  (instr_d),
    .valid_d  (valid_d),
    .ctrl_d   (ctrl_d),
    .imm_src_d(imm_src_d),
    .illegal_d(illegal_d)
  );

  function automatic logic hit(input ctrl_t s, input logic [4:0] r);
    return s.valid & s.reg_write & (s.rd != 5'd0) & (s.rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input ctrl_t m, input ctrl_t w, input logic [4:0] r);
    if (hit(m, r))      return 2'b10;
    else if (hit(w, r)) return 2'b01;
    else                return 2'b00;
  endfunction

  always_comb begin
    // hazard outputs are masked during reset and for one cycle afterwards
    quiet    = rst | rst_q;
    md_in_e  = (M_EXT != 0) & ctrl_e.valid & ctrl_e.is_md;
    // the start cycle holds E too, so the MD op never leaves EX before md_done
    md_hold  = ((state == IDLE) & md_in_e) | ((state == BUSY) & ~md_done);
    load_use = ctrl_e.valid & (ctrl_e.result_src == RES_MEM) & (ctrl_e.rd != 5'd0) &
               ((ctrl_e.rd == ctrl_d.rs1) | (ctrl_e.rd == ctrl_d.rs2));
    raw      = (FWD_EN == 0) & (hit(ctrl_e, ctrl_d.rs1) | hit(ctrl_e, ctrl_d.rs2) |
                                hit(ctrl_m, ctrl_d.rs1) | hit(ctrl_m, ctrl_d.rs2));
    hazard   = load_use | raw;
    stall_f  = ~quiet & ~pcsrc_e & (hazard | md_hold);
    stall_d  = stall_f;
    flush_d  = ~quiet & pcsrc_e;
    flush_e  = ~quiet & (pcsrc_e | (hazard & ~md_hold));
    e_hold   = md_hold & ~flush_d;
    md_start = ~quiet & (state == IDLE) & md_in_e;
    fwd_a_e  = '0;
    fwd_b_e  = '0;
    if (FWD_EN != 0 && !quiet) begin
      fwd_a_e = fwd_sel(ctrl_m, ctrl_w, ctrl_e.rs1);
      fwd_b_e = fwd_sel(ctrl_m, ctrl_w, ctrl_e.rs2);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (md_in_e) state_nx = BUSY;
      BUSY:    if (md_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rst_q  <= 1'b1;
      ctrl_e <= '0;
      ctrl_m <= '0;
      ctrl_w <= '0;
    end else begin
      state  <= state_nx;
      rst_q  <= 1'b0;
      if (!e_hold) ctrl_e <= flush_e ? '0 : ctrl_d;
      ctrl_m <= e_hold ? '0 : ctrl_e;
      ctrl_w <= ctrl_m;
    end
  end

endmodule
